// File: rtl/imem_fetch_port_if.sv
// Fetch handshake bundle between the PC/fetch stage (master) and the instruction memory (slave).
interface imem_fetch_port_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_instr;
    logic [31:0]     rsp_addr;
    logic            rsp_fault;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );
endinterface

// File: rtl/imem_fetch_port.sv
// Instruction memory with a registered, flow-controlled fetch port and a program-load port.
// Define IMEM_FAULT_CNT_EN to build the saturating fault counter on fault_cnt.
module imem_fetch_port #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    imem_fetch_port_if.slave fetch,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [XLEN-1:0] prog_data,
    output logic [7:0]      fault_cnt
);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    // Contents power up as NOPs and are deliberately outside the reset domain.
    logic [XLEN-1:0] r_mem [DEPTH] = '{default: NOP};

    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_instr;
    logic [31:0]     r_rsp_addr;
    logic            r_rsp_fault;

    logic            w_req_ready;
    logic            w_accept;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_fault;
    logic [AW-1:0]   w_index;

    assign w_req_ready    = !r_rsp_valid || fetch.rsp_ready;
    assign w_accept       = fetch.req_valid && w_req_ready;
    assign w_index        = fetch.req_addr[AW+1:2];
    assign w_misaligned   = |fetch.req_addr[1:0];
    assign w_out_of_range = |fetch.req_addr[31:AW+2];
    assign w_fault        = w_misaligned || w_out_of_range;

    // Read and write share the edge; the read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (prog_we && !rst) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= NOP;
            r_rsp_addr  <= '0;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_instr <= w_fault ? NOP : r_mem[w_index];
            r_rsp_addr  <= fetch.req_addr;
            r_rsp_fault <= w_fault;
        end else if (fetch.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef IMEM_FAULT_CNT_EN
    logic [7:0] r_fault_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_cnt <= '0;
        end else if (w_accept && w_fault && (r_fault_cnt != 8'hFF)) begin
            r_fault_cnt <= r_fault_cnt + 8'd1;
        end
    end

    assign fault_cnt = r_fault_cnt;
`else
    assign fault_cnt = '0;
`endif

    assign fetch.req_ready = w_req_ready;
    assign fetch.rsp_valid = r_rsp_valid;
    assign fetch.rsp_instr = r_rsp_instr;
    assign fetch.rsp_addr  = r_rsp_addr;
    assign fetch.rsp_fault = r_rsp_fault;
endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: expected responses queued at accept, compared while presented.
module tb_imem_fetch_port;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [XLEN-1:0] prog_data;
    logic [7:0]      fault_cnt;

    always #5 clk = ~clk;

    imem_fetch_port_if #(.XLEN(XLEN)) bus();

    imem_fetch_port #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch    (bus),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .fault_cnt(fault_cnt)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        fault;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] mdl[DEPTH];
    int unsigned mdl_fcnt;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_fcnt();
`ifdef IMEM_FAULT_CNT_EN
        return mdl_fcnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic rsp_t model_rsp(input logic [31:0] a);
        rsp_t r;
        r.addr  = a;
        r.fault = (a % 4 != 0) || (a >= DEPTH * 4);
        r.instr = r.fault ? NOP : mdl[a / 4];
        return r;
    endfunction

    // One clock: check what is presented, advance the model for the coming edge, step past the edge.
    task automatic cycle();
        rsp_t e;
        logic exp_rdy;
        @(negedge clk);
        check_val("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, sb.size() != 0});
        exp_rdy = (sb.size() == 0) || bus.rsp_ready;
        check_val("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_rdy});
        check_val("fault_cnt", {24'd0, fault_cnt}, exp_fcnt());
        if (sb.size() != 0) begin
            e = sb[0];
            check_val("rsp_instr", bus.rsp_instr, e.instr);
            check_val("rsp_addr",  bus.rsp_addr,  e.addr);
            check_val("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, e.fault});
            if (bus.rsp_ready) void'(sb.pop_front());
        end
        if (bus.req_valid && exp_rdy) begin
            e = model_rsp(bus.req_addr);
            sb.push_back(e);
            if (e.fault && mdl_fcnt < 255) mdl_fcnt++;
        end
        if (prog_we && !rst) mdl[prog_addr] = prog_data;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] a, input logic rr,
                         input logic we, input logic [AW-1:0] pa, input logic [31:0] pd);
        bus.req_valid = rv;
        bus.req_addr  = a;
        bus.rsp_ready = rr;
        prog_we       = we;
        prog_addr     = pa;
        prog_data     = pd;
        cycle();
    endtask

    task automatic fetch_one(input logic [31:0] a);
        drive(1'b1, a, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic prog(input logic [AW-1:0] pa, input logic [31:0] pd);
        drive(1'b0, '0, 1'b1, 1'b1, pa, pd);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = NOP;
        mdl_fcnt      = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        prog_we       = 1'b0;
        prog_addr     = '0;
        prog_data     = '0;

        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check_val("rst_instr", bus.rsp_instr, NOP);
        check_val("rst_addr",  bus.rsp_addr, 32'd0);
        check_val("rst_fault", {31'd0, bus.rsp_fault}, 32'd0);
        check_val("rst_fcnt",  {24'd0, fault_cnt}, 32'd0);
        rst = 1'b0;

        prog(6'd3, 32'h0050_0093);
        fetch_one(32'h0C);
        idle();

        prog(6'd1, 32'h1111_1111);
        prog(6'd2, 32'h2222_2222);
        fetch_one(32'h00);
        fetch_one(32'h04);
        fetch_one(32'h08);
        idle();
        idle();

        fetch_one(32'h04);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h08, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 32'h08, 1'b1, 1'b0, '0, '0);
        idle();
        idle();

        fetch_one(32'h06);
        fetch_one(32'h100);
        idle();
        idle();
`ifdef IMEM_FAULT_CNT_EN
        check_val("fcnt_two", {24'd0, fault_cnt}, 32'd2);
`else
        check_val("fcnt_two", {24'd0, fault_cnt}, 32'd0);
`endif

        drive(1'b1, 32'h14, 1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
        fetch_one(32'h14);
        idle();
        idle();

        for (int i = 0; i < 300; i++) fetch_one(32'h0000_1001);
        idle();
        idle();
`ifdef IMEM_FAULT_CNT_EN
        check_val("fcnt_sat", {24'd0, fault_cnt}, 32'd255);
`else
        check_val("fcnt_sat", {24'd0, fault_cnt}, 32'd0);
`endif

        fetch_one(32'h0C);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        // Response now held; a write attempted during reset must be dropped.
        prog_we   = 1'b1;
        prog_addr = 6'd3;
        prog_data = 32'hBAD0_BAD0;
        #2;
        rst = 1'b1;
        #1;
        check_val("async_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_val("async_ready", {31'd0, bus.req_ready}, 32'd1);
        check_val("async_fcnt",  {24'd0, fault_cnt}, 32'd0);
        sb.delete();
        mdl_fcnt = 0;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        rst     = 1'b0;

        fetch_one(32'h0C);
        fetch_one(32'h14);
        fetch_one(32'h04);
        idle();
        idle();

        for (int i = 0; i < 10 && sb.size() != 0; i++) idle();
        check_val("drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised instruction memory with a registered, flow-controlled fetch port and a program-load write port. It sits between the PC/fetch stage and the decode stage. It replaces the fixed 64-word combinational instruction store. It also adds backpressure, misaligned/out-of-range fault reporting and run-time program loading.

## Interface
- XLEN, 32: instruction word width in bits.
- DEPTH, 64: number of words; power of two, 4..4096.
- AW, $clog2(DEPTH): word-index width of the program port.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  fetch request accepted this cycle when high with req_valid.
- req_addr  input  32  byte address of the fetch.
- rsp_valid  output  1  response holds a fetch result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_instr  output  XLEN  fetched instruction.
- rsp_addr  output  32  byte address the response belongs to.
- rsp_fault  output  1  response is a fault (misaligned or out of range).
- prog_we  input  1  program-load write strobe.
- prog_addr  input  AW  word index to write.
- prog_data  input  XLEN  word to write.
- fault_cnt  output  8  saturating fault count (see Configuration).

## Operation
- Storage: DEPTH x XLEN array.
  - Every word initialises to NOP 0x00000013 at time zero.
  - Contents are not affected by rst.
- Word index = req_addr[AW+1:2].
- Fault conditions:
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: req_addr[31:AW+2] != 0.
  - On either fault: rsp_fault=1 and rsp_instr=0x00000013.
- Output stage is a single response register.
  - req_ready = !rsp_valid || rsp_ready.
  - Accept (req_valid && req_ready):
    - Load rsp_instr/rsp_addr/rsp_fault.
    - Set rsp_valid=1.
  - rsp_valid && rsp_ready without an accept: clear rsp_valid.
  - rsp_valid && !rsp_ready:
    - Response held stable.
    - No new accept.
    - Memory writes still proceed.
- Program port:
  - prog_we=1 writes prog_data to word prog_addr on the rising edge.
  - prog_we is ignored while rst=1.
- Same-cycle write and accepted read of the same word: response returns the OLD contents (read-before-write). The next fetch sees the new data.
- rsp_addr and rsp_fault are registered with the instruction and describe exactly the returned word.

## Timing
- Reset values: rsp_valid=0, rsp_instr=0x00000013, rsp_addr=0, rsp_fault=0, fault_cnt=0.
  - req_ready=1 during and after reset (derived from rsp_valid=0).
- Read latency: 1 cycle. A request accepted at edge N is presented from edge N onward (valid in cycle N+1).
- Sustained throughput: one fetch per cycle while rsp_ready=1.
- Reset asserted mid-stream: rsp_valid drops immediately (asynchronous); any held response is discarded; memory retains contents.
- Reset deassertion: the first request can be accepted on the first rising edge with rst=0.

## Configuration
- IMEM_FAULT_CNT_EN defined:
  - fault_cnt increments by 1 on every accepted faulting request.
  - It saturates at 255 and clears only on rst.
- Not defined: fault_cnt is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Test plan
- Reset, then prog-write word 3 = 0x00500093, then fetch 0x0C with rsp_ready=1 -> next cycle rsp_valid=1, rsp_instr=0x00500093, rsp_addr=0x0C, rsp_fault=0.
- Back-to-back fetches 0x00, 0x04, 0x08 with rsp_ready=1 -> three consecutive valid responses in order, req_ready stays 1.
- Fetch 0x04 then hold rsp_ready=0 for 3 cycles while req_valid=1 at 0x08 -> response 0x04 held stable, req_ready=0. On release, 0x08 is accepted and follows one cycle later.
- Fetch 0x06 and 0x100 (DEPTH=64) -> rsp_fault=1 and rsp_instr=0x00000013 for each. With IMEM_FAULT_CNT_EN, fault_cnt=2; after 300 faults, fault_cnt=255.
- Same-cycle prog-write word 5 = 0xDEADBEEF and fetch 0x14 -> rsp_instr is the old value 0x00000013; a fetch of 0x14 next cycle returns 0xDEADBEEF.
- Assert rst while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately. Programmed words are intact after release.
